mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the master side; mdu_ctrl is the slave.
interface mdu_ctrl_if;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output mdu_valid, mdu_op, src_a, src_b, flush,
    input  busy, hi, lo, done
  );

  modport slave (
    input  mdu_valid, mdu_op, src_a, src_b, flush,
    output busy, hi, lo, done
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency multiply, 32-step restoring
// divide on magnitudes, HI/LO architectural registers with MTHI/MTLO writes.
//
// state | meaning
// IDLE  | waiting; accepts MULT/MULTU/DIV/DIVU starts and MTHI/MTLO writes
// MUL   | multiply in flight, mul counter runs MUL_LAT-1 down to 0
// DIV   | one restoring divide step per cycle, div counter 0..31
// DONE  | result committed to HI/LO, done pulse, stalled instruction retires
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic       clk,
  input logic       resetn,
  mdu_ctrl_if.slave mdu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] MUL_LOAD = 2'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_c;
  logic        done_c;

  // Product datapath: sign-extend only for MULT, so one 64-bit multiply serves both
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  // Divide step: shift one dividend bit into the partial remainder, try subtract
  logic [31:0] div_mag;
  logic [32:0] rem_shift;
  logic [33:0] trial;
  logic [31:0] rem_step, quo_step;
  logic        q_neg, r_neg;
  logic [31:0] q_final, r_final;

  assign div_mag   = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = {1'b0, rem_shift} - {2'b00, div_mag};

  always_comb begin
    if (!trial[33]) begin
      rem_step = trial[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end else begin
      rem_step = rem_shift[31:0];
      quo_step = {quo_q[30:0], 1'b0};
    end
  end

  assign q_neg   = sgn_q & (a_q[31] ^ b_q[31]);
  assign r_neg   = sgn_q & a_q[31];
  assign q_final = q_neg ? (32'd0 - quo_step) : quo_step;
  assign r_final = r_neg ? (32'd0 - rem_step) : rem_step;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mul_cnt_d = mul_cnt_q;
    div_cnt_d = div_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_c    = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mdu.mdu_valid && !mdu.flush) begin
          unique case (mdu.mdu_op)
            OP_MULT, OP_MULTU: begin
              busy_c    = 1'b1;
              state_d   = MUL;
              a_d       = mdu.src_a;
              b_d       = mdu.src_b;
              sgn_d     = (mdu.mdu_op == OP_MULT);
              mul_cnt_d = MUL_LOAD;
            end
            OP_DIV, OP_DIVU: begin
              busy_c    = 1'b1;
              state_d   = DIV;
              a_d       = mdu.src_a;
              b_d       = mdu.src_b;
              sgn_d     = (mdu.mdu_op == OP_DIV);
              rem_d     = 32'd0;
              quo_d     = ((mdu.mdu_op == OP_DIV) && mdu.src_a[31]) ?
                          (32'd0 - mdu.src_a) : mdu.src_a;
              div_cnt_d = 5'd0;
            end
            OP_MTHI: hi_d = mdu.src_a;
            OP_MTLO: lo_d = mdu.src_a;
            default: ;
          endcase
        end
      end

      MUL: begin
        busy_c = 1'b1;
        if (mdu.flush) begin
          state_d   = IDLE;
          mul_cnt_d = 2'd0;
        end else if (mul_cnt_q == 2'd0) begin
          state_d = DONE;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
        end else begin
          mul_cnt_d = mul_cnt_q - 2'd1;
        end
      end

      DIV: begin
        busy_c = 1'b1;
        if (mdu.flush) begin
          state_d   = IDLE;
          div_cnt_d = 5'd0;
        end else begin
          rem_d     = rem_step;
          quo_d     = quo_step;
          div_cnt_d = div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd31) begin
            state_d = DONE;
            // Zero divisor still runs the full 32 steps, then reports a fixed pattern
            if (b_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = r_final;
              lo_d = q_final;
            end
          end
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sgn_q     <= 1'b0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      mul_cnt_q <= 2'd0;
      div_cnt_q <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mul_cnt_q <= mul_cnt_d;
      div_cnt_q <= div_cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // busy is combinational off the issue bus, so hold it low while reset is asserted
  assign mdu.busy = busy_c & resetn;
  assign mdu.done = done_c;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule
